// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port among writeback, load and mul/div,
// and tracks outstanding long-latency destinations in a 32-bit pending scoreboard.
module rf_write_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned RR_INIT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ld_valid,
  output logic            ld_ready,
  input  logic [4:0]      ld_rd,
  input  logic [XLEN-1:0] ld_data,
  input  logic            md_valid,
  output logic            md_ready,
  input  logic [4:0]      md_rd,
  input  logic [XLEN-1:0] md_data,
  input  logic            iss_valid,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  output logic            rf_regwrite,
  output logic [4:0]      rf_rd,
  output logic [XLEN-1:0] rf_wd,
  output logic [1:0]      rf_src,
  output logic [31:0]     pending
);

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_WB   = 2'd1,
    SRC_LD   = 2'd2,
    SRC_MD   = 2'd3
  } src_e;

  localparam logic RR_RST = (RR_INIT != 0);

  logic            rf_regwrite_q, rf_regwrite_d;
  logic [4:0]      rf_rd_q, rf_rd_d;
  logic [XLEN-1:0] rf_wd_q, rf_wd_d;
  src_e            rf_src_q, rf_src_d;
  logic [31:0]     pending_q, pending_d;
  logic            rr_q, rr_d;

  logic            grant_ld, grant_md;
  logic            ld_hs, md_hs, iss_hs;
  logic            sel_vld;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_wd;
  src_e            sel_src;

  // wb always wins; between ld and md the round-robin pointer breaks ties
  always_comb begin
    grant_ld  = !wb_valid && ld_valid && (!md_valid || !rr_q);
    grant_md  = !wb_valid && md_valid && (!ld_valid || rr_q);
    ld_ready  = !rst && grant_ld;
    md_ready  = !rst && grant_md;
    ld_hs     = ld_valid && ld_ready;
    md_hs     = md_valid && md_ready;
    iss_ready = !rst && ((iss_rd == 5'd0) || !pending_q[iss_rd]);
    iss_hs    = iss_valid && iss_ready;
  end

  always_comb begin
    sel_vld = 1'b0;
    sel_rd  = '0;
    sel_wd  = '0;
    sel_src = SRC_NONE;
    if (wb_valid) begin
      sel_vld = 1'b1;
      sel_rd  = wb_rd;
      sel_wd  = wb_data;
      sel_src = SRC_WB;
    end else if (ld_hs) begin
      sel_vld = 1'b1;
      sel_rd  = ld_rd;
      sel_wd  = ld_data;
      sel_src = SRC_LD;
    end else if (md_hs) begin
      sel_vld = 1'b1;
      sel_rd  = md_rd;
      sel_wd  = md_data;
      sel_src = SRC_MD;
    end
  end

  // Writes to x0 complete the handshake but never reach the register file
  always_comb begin
    rf_regwrite_d = sel_vld && (sel_rd != 5'd0);
    rf_rd_d       = rf_regwrite_d ? sel_rd : rf_rd_q;
    rf_wd_d       = rf_regwrite_d ? sel_wd : rf_wd_q;
    rf_src_d      = rf_regwrite_d ? sel_src : SRC_NONE;

    rr_d = rr_q;
    if (ld_hs) begin
      rr_d = 1'b1;
    end else if (md_hs) begin
      rr_d = 1'b0;
    end
  end

  // Clear on the register-file commit edge; a same-edge set takes precedence
  always_comb begin
    pending_d = pending_q;
    if (rf_regwrite_q && ((rf_src_q == SRC_LD) || (rf_src_q == SRC_MD))) begin
      pending_d[rf_rd_q] = 1'b0;
    end
    if (iss_hs && (iss_rd != 5'd0)) begin
      pending_d[iss_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_regwrite_q <= 1'b0;
      rf_rd_q       <= '0;
      rf_wd_q       <= '0;
      rf_src_q      <= SRC_NONE;
      pending_q     <= '0;
      rr_q          <= RR_RST;
    end else begin
      rf_regwrite_q <= rf_regwrite_d;
      rf_rd_q       <= rf_rd_d;
      rf_wd_q       <= rf_wd_d;
      rf_src_q      <= rf_src_d;
      pending_q     <= pending_d;
      rr_q          <= rr_d;
    end
  end

  assign rf_regwrite = rf_regwrite_q;
  assign rf_rd       = rf_rd_q;
  assign rf_wd       = rf_wd_q;
  assign rf_src      = rf_src_q;
  assign pending     = pending_q;

  // A writeback to a destination still owed by load or mul/div is an issue-stage bug
  a_wb_to_pending: assert property (@(posedge clk) disable iff (rst)
    !(wb_valid && pending_q[wb_rd]));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: priority, round-robin, x0 filtering,
// scoreboard set/clear timing and mid-operation reset.
module tb_rf_write_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_rd;
  logic [31:0] md_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic        rf_regwrite;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wd;
  logic [1:0]  rf_src;
  logic [31:0] pending;

  int checks = 0;
  int errors = 0;

  rf_write_arbiter #(.XLEN(32), .RR_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rf_regwrite(rf_regwrite), .rf_rd(rf_rd), .rf_wd(rf_wd), .rf_src(rf_src),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
    md_valid = 1'b0; md_rd = '0; md_data = '0;
    iss_valid = 1'b0; iss_rd = '0;
    tick();
    tick();
    rst = 1'b0;
    tick(); tick(); tick();

    // reset / idle
    iss_rd = 5'd5;
    #1;
    chk("idle_regwrite", {31'd0, rf_regwrite}, 32'd0);
    chk("idle_pending", pending, 32'd0);
    chk("idle_src", {30'd0, rf_src}, 32'd0);
    chk("idle_rd", {27'd0, rf_rd}, 32'd0);
    chk("idle_wd", rf_wd, 32'd0);
    chk("idle_iss_ready", {31'd0, iss_ready}, 32'd1);

    // wb beats ld, then ld granted once wb drops
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
    ld_valid = 1'b1; ld_rd = 5'd4; ld_data = 32'h0000_0044;
    #1;
    chk("wb_prio_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("wb_prio_md_ready", {31'd0, md_ready}, 32'd0);
    tick();
    chk("wb_regwrite", {31'd0, rf_regwrite}, 32'd1);
    chk("wb_rd", {27'd0, rf_rd}, 32'd3);
    chk("wb_wd", rf_wd, 32'hDEADBEEF);
    chk("wb_src", {30'd0, rf_src}, 32'd1);
    wb_valid = 1'b0;
    #1;
    chk("ld_after_wb_ready", {31'd0, ld_ready}, 32'd1);
    tick();
    ld_valid = 1'b0;
    chk("ld_rd", {27'd0, rf_rd}, 32'd4);
    chk("ld_wd", rf_wd, 32'h44);
    chk("ld_src", {30'd0, rf_src}, 32'd2);
    chk("ld_pending", pending, 32'd0);

    // restart so round-robin begins at RR_INIT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd6;  ld_data = 32'h0000_0606;
    md_valid = 1'b1; md_rd = 5'd10; md_data = 32'h0000_0A0A;
    #1;
    chk("rr1_ld_ready", {31'd0, ld_ready}, 32'd1);
    chk("rr1_md_ready", {31'd0, md_ready}, 32'd0);
    tick();
    chk("rr1_rd", {27'd0, rf_rd}, 32'd6);
    chk("rr1_src", {30'd0, rf_src}, 32'd2);
    ld_rd = 5'd7; ld_data = 32'h0000_0707;
    #1;
    chk("rr2_md_ready", {31'd0, md_ready}, 32'd1);
    chk("rr2_ld_ready", {31'd0, ld_ready}, 32'd0);
    tick();
    chk("rr2_rd", {27'd0, rf_rd}, 32'd10);
    chk("rr2_wd", rf_wd, 32'h0A0A);
    chk("rr2_src", {30'd0, rf_src}, 32'd3);
    md_rd = 5'd11; md_data = 32'h0000_0B0B;
    #1;
    chk("rr3_ld_ready", {31'd0, ld_ready}, 32'd1);
    tick();
    chk("rr3_rd", {27'd0, rf_rd}, 32'd7);
    ld_rd = 5'd8; ld_data = 32'h0000_0808;
    #1;
    chk("rr4_md_ready", {31'd0, md_ready}, 32'd1);
    tick();
    chk("rr4_rd", {27'd0, rf_rd}, 32'd11);
    chk("rr4_src", {30'd0, rf_src}, 32'd3);
    ld_valid = 1'b0;
    md_valid = 1'b0;

    // scoreboard: issue rd 8, block re-issue, clear on md commit
    iss_valid = 1'b1; iss_rd = 5'd8;
    #1;
    chk("iss8_ready", {31'd0, iss_ready}, 32'd1);
    tick();
    chk("iss8_pending", pending, 32'h0000_0100);
    chk("iss8_again_ready", {31'd0, iss_ready}, 32'd0);
    iss_valid = 1'b0;
    md_valid = 1'b1; md_rd = 5'd8; md_data = 32'h12;
    #1;
    chk("md8_ready", {31'd0, md_ready}, 32'd1);
    tick();
    md_valid = 1'b0;
    chk("md8_rd", {27'd0, rf_rd}, 32'd8);
    chk("md8_wd", rf_wd, 32'h12);
    chk("md8_src", {30'd0, rf_src}, 32'd3);
    chk("md8_pending_pre_commit", pending, 32'h0000_0100);
    chk("md8_iss_ready_pre_commit", {31'd0, iss_ready}, 32'd0);
    tick();
    chk("md8_pending_committed", pending, 32'd0);
    chk("md8_iss_ready_post", {31'd0, iss_ready}, 32'd1);
    chk("idle_after_md_regwrite", {31'd0, rf_regwrite}, 32'd0);
    chk("idle_after_md_rd_hold", {27'd0, rf_rd}, 32'd8);
    chk("idle_after_md_wd_hold", rf_wd, 32'h12);

    // x0 destination: handshake completes, no write
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'hFFFFFFFF;
    #1;
    chk("x0_ld_ready", {31'd0, ld_ready}, 32'd1);
    tick();
    ld_valid = 1'b0;
    chk("x0_regwrite", {31'd0, rf_regwrite}, 32'd0);
    chk("x0_src", {30'd0, rf_src}, 32'd0);
    chk("x0_pending", pending, 32'd0);

    // reset before commit of a pending load
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0;
    chk("iss5_pending", pending, 32'h0000_0020);
    ld_valid = 1'b1; ld_rd = 5'd5; ld_data = 32'h55;
    #1;
    chk("ld5_ready", {31'd0, ld_ready}, 32'd1);
    tick();
    chk("ld5_regwrite", {31'd0, rf_regwrite}, 32'd1);
    chk("ld5_rd", {27'd0, rf_rd}, 32'd5);
    rst = 1'b1;
    iss_rd = 5'd0;
    #1;
    chk("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("rst_md_ready", {31'd0, md_ready}, 32'd0);
    chk("rst_iss_ready", {31'd0, iss_ready}, 32'd0);
    tick();
    chk("rst_regwrite", {31'd0, rf_regwrite}, 32'd0);
    chk("rst_rd", {27'd0, rf_rd}, 32'd0);
    chk("rst_wd", rf_wd, 32'd0);
    chk("rst_src", {30'd0, rf_src}, 32'd0);
    chk("rst_pending", pending, 32'd0);
    ld_valid = 1'b0;
    rst = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single register-file write port (regwrite/rd/wd) among three producers: the core writeback stage, the load unit and the mul/div unit.
- Keeps a 32-bit pending-write scoreboard for long-latency destinations (load, mul/div). The issue stage stalls on WAW/RAW hazards against those destinations.
- Sits between the execution units and the register file. Its registered outputs drive the register-file write inputs directly.

Parameters:
- XLEN, 32, data width of all write data paths.
- RR_INIT, 0, initial round-robin pointer (0 = load unit preferred first, 1 = mul/div preferred first).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- wb_valid  in  1  core writeback request; no ready, always granted
- wb_rd  in  5  core writeback destination
- wb_data  in  XLEN  core writeback data
- ld_valid  in  1  load-return request
- ld_ready  out  1  load-return accepted this cycle
- ld_rd  in  5  load destination
- ld_data  in  XLEN  load data
- md_valid  in  1  mul/div result request
- md_ready  out  1  mul/div result accepted this cycle
- md_rd  in  5  mul/div destination
- md_data  in  XLEN  mul/div data
- iss_valid  in  1  issue of a load or mul/div op
- iss_rd  in  5  its destination
- iss_ready  out  1  issue accepted (no pending conflict)
- rf_regwrite  out  1  register-file write enable
- rf_rd  out  5  register-file write address
- rf_wd  out  XLEN  register-file write data
- rf_src  out  2  source of current write: 0 none, 1 wb, 2 ld, 3 md
- pending  out  32  scoreboard; bit n = write to xn outstanding

Behaviour:
- Reset values: rf_regwrite=0, rf_rd=0, rf_wd=0, rf_src=0, pending=0, rr=RR_INIT.
- While rst=1: ld_ready, md_ready and iss_ready are forced to 0. Reset mid-operation drops any in-flight request and clears the scoreboard.
- Priority (combinational, per cycle):
  - wb_valid=1: wb wins; ld_ready=md_ready=0.
  - Otherwise, only one of ld/md valid: that one is granted.
  - Otherwise, both valid: rr selects (0 ld, 1 md).
  - ready is asserted only for the granted source. A handshake is valid&ready.
- rr update: after an ld grant, rr=1; after an md grant, rr=0. A wb grant or an idle cycle leaves rr unchanged.
- Latency: the grant in cycle N is registered into rf_* at edge N+1. The register file commits at edge N+2. Exactly one write per cycle, with back-to-back grants supported.
- Granted rd=0: the handshake completes, but rf_regwrite=0 and rf_src=0 (x0 filtered).
- Granted rd!=0: rf_regwrite=1, with rf_rd/rf_wd/rf_src from the winner.
- No wb grant and no ld/md handshake: rf_regwrite=0 next cycle. rf_rd and rf_wd hold their previous values.
- Scoreboard set: iss_valid & iss_ready & iss_rd!=0 sets pending[iss_rd] at the next edge.
- Scoreboard clear: pending[rf_rd] clears on an edge where rf_regwrite=1 and rf_src is 2 or 3, i.e. the commit edge, so readers never see stale data.
- Same bit set and cleared on the same edge: set wins (bit stays 1).
- iss_ready = !rst & (iss_rd==0 | !pending[iss_rd]). It uses registered pending only, with no same-cycle clear bypass.
- wb targeting a pending rd is a protocol violation. The write is still performed and pending is unchanged. A simulation-only assertion flags it.
- ld/md results for an rd that is not pending are written normally and the scoreboard is unchanged.

Test Plan:
- Reset, then idle 3 cycles -> rf_regwrite=0, pending=0, iss_ready=1 for iss_rd=5.
- wb_valid=1 rd=3 data=0xDEADBEEF with ld_valid=1 rd=4 in the same cycle -> ld_ready=0. Next cycle rf_rd=3, rf_wd=0xDEADBEEF, rf_src=1. With wb dropped, ld is granted and rf_rd=4, rf_src=2 one cycle later.
- ld and md both valid for 4 cycles (ld rd=6..9, md rd=10..13), RR_INIT=0 -> grants alternate ld,md,ld,md. rf_rd sequence is 6,10,7,11.
- Issue rd=8 -> pending[8]=1; second issue rd=8 -> iss_ready=0. md returns rd=8 data=0x12 -> pending[8] clears at the commit edge (2 edges after the handshake), and iss_ready=1 the cycle after that.
- ld handshake with rd=0 data=0xFFFFFFFF -> ld_ready=1, rf_regwrite=0 next cycle, pending unchanged.
- pending[5]=1 and ld rd=5 accepted, then rst asserted before commit -> all rf_* and pending return to 0 and ld_ready=0 during rst.
